// File: rtl/sram_byte_ctrl.sv
// Single-byte request sequencer for the SRAM byte array: decodes word lines, times the
// read/write pulses and returns captured read data on a one-cycle response strobe.
module sram_byte_ctrl #(
    parameter int unsigned ADDR_W    = 4,
    parameter int unsigned NUM_BYTES = 16,
    parameter int unsigned PULSE_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [7:0]             req_wdata,
    output logic                   resp_valid,
    output logic [7:0]             resp_rdata,
    output logic                   resp_err,
    output logic [NUM_BYTES-1:0]   WL,
    output logic [7:0]             sram_din,
    output logic                   write_pulse,
    output logic                   read_pulse,
    input  logic [NUM_BYTES*8-1:0] rd_bus
);

    localparam int unsigned CNT_W = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StHold,
        StDone
    } state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [7:0]         r_wdata;
    logic [7:0]         r_rdata;
    logic               r_err;

    logic                 w_accept;
    logic                 w_in_range;
    logic                 w_wl_active;
    logic [NUM_BYTES-1:0] w_wl_dec;
    logic [7:0]           w_rd_byte;

    assign w_accept   = req_valid && req_ready;
    assign w_in_range = (32'(r_addr) < NUM_BYTES);

    // Out-of-range addresses match no decoder row, so WL and the read mux stay zero.
    always_comb begin
        w_wl_dec  = '0;
        w_rd_byte = 8'h00;
        for (int unsigned i = 0; i < NUM_BYTES; i++) begin
            if (32'(r_addr) == i) begin
                w_wl_dec[i] = 1'b1;
                w_rd_byte   = rd_bus[8*i +: 8];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = StSetup;
                end
            end
            StSetup: begin
                w_state_nxt = StPulse;
                w_cnt_nxt   = CNT_W'(PULSE_CYC - 1);
            end
            StPulse: begin
                if (r_cnt == '0) begin
                    w_state_nxt = StHold;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StHold:  w_state_nxt = StDone;
            StDone:  w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
        end else if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
        end
    end

    // Capture on the HOLD exit edge, after the byte has latched on read_pulse falling.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
            r_err   <= 1'b0;
        end else if (r_state == StHold) begin
            r_err <= !w_in_range;
            if (!r_we) begin
                r_rdata <= w_rd_byte;
            end
        end
    end

    always_comb begin
        w_wl_active = (r_state == StSetup) || (r_state == StPulse) || (r_state == StHold);
        req_ready   = (r_state == StIdle);
        resp_valid  = (r_state == StDone);
        resp_rdata  = r_rdata;
        resp_err    = r_err;
        WL          = w_wl_active ? w_wl_dec : '0;
        sram_din    = (w_wl_active && r_we) ? r_wdata : 8'h00;
        write_pulse = (r_state == StPulse) && r_we;
        read_pulse  = (r_state == StPulse) && !r_we;
    end

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Scoreboard bench for sram_byte_ctrl with an attached byte-array model (12 bytes, so
// addresses 12..15 exercise the out-of-range path).
module tb_sram_byte_ctrl;

    localparam int unsigned ADDR_W    = 4;
    localparam int unsigned NUM_BYTES = 12;
    localparam int unsigned PULSE_CYC = 2;

    logic                   clk;
    logic                   rst_n;
    logic                   req_valid;
    logic                   req_ready;
    logic                   req_we;
    logic [ADDR_W-1:0]      req_addr;
    logic [7:0]             req_wdata;
    logic                   resp_valid;
    logic [7:0]             resp_rdata;
    logic                   resp_err;
    logic [NUM_BYTES-1:0]   WL;
    logic [7:0]             sram_din;
    logic                   write_pulse;
    logic                   read_pulse;
    logic [NUM_BYTES*8-1:0] rd_bus;

    sram_byte_ctrl #(
        .ADDR_W   (ADDR_W),
        .NUM_BYTES(NUM_BYTES),
        .PULSE_CYC(PULSE_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .WL         (WL),
        .sram_din   (sram_din),
        .write_pulse(write_pulse),
        .read_pulse (read_pulse),
        .rd_bus     (rd_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Byte array stand-in: a byte takes sram_din while write_pulse and its WL are high.
    logic [7:0] sram_mem [NUM_BYTES];
    logic [7:0] seed_val [NUM_BYTES];
    logic       do_seed;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (do_seed) sram_mem[i] <= seed_val[i];
            else if (write_pulse && WL[i]) sram_mem[i] <= sram_din;
        end
    end

    for (genvar g = 0; g < NUM_BYTES; g++) begin : g_rd
        assign rd_bus[8*g +: 8] = sram_mem[g];
    end

    typedef struct {
        bit         we;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] rd;
        bit         err;
        int         acc;
    } item_t;

    item_t      exp_q[$];
    item_t      mon_cur;
    logic [7:0] ref_mem [NUM_BYTES];
    logic [7:0] last_rd;
    int         cyc;
    int         run;
    int         n_pass;
    int         n_total;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [NUM_BYTES-1:0] exp_wl(input logic [3:0] a);
        logic [NUM_BYTES-1:0] v;
        v = '0;
        if (32'(a) < NUM_BYTES) v[a] = 1'b1;
        return v;
    endfunction

    // Monitor: protocol invariants every cycle, scoreboard compare on resp_valid.
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            run = 0;
        end else begin
            chk("req_ready", req_ready, exp_q.size() == 0);
            chk("wl_onehot", $countones(WL) <= 1, 1);
            chk("pulse_excl", read_pulse && write_pulse, 0);
            if (exp_q.size() > 0) begin
                mon_cur = exp_q[0];
                if (write_pulse || read_pulse) begin
                    run++;
                    chk("pulse_wl", WL, exp_wl(mon_cur.addr));
                    chk("pulse_kind", write_pulse, mon_cur.we);
                    chk("pulse_din", sram_din, mon_cur.we ? mon_cur.wdata : 8'h00);
                end else if (run > 0) begin
                    chk("pulse_width", run, PULSE_CYC);
                    chk("hold_wl", WL, exp_wl(mon_cur.addr));
                    run = 0;
                end
                if (resp_valid) begin
                    chk("latency", cyc - mon_cur.acc, 3 + PULSE_CYC);
                    chk("resp_rdata", resp_rdata, mon_cur.rd);
                    chk("resp_err", resp_err, mon_cur.err);
                    chk("done_wl", WL, 0);
                    void'(exp_q.pop_front());
                end
            end else begin
                chk("idle_quiet", {resp_valid, write_pulse, read_pulse, |WL}, 0);
            end
        end
    end

    // Called at a negedge; leaves req_valid high on return (at the next negedge).
    task automatic issue(input bit we, input logic [3:0] addr, input logic [7:0] wd,
                         input bit upd);
        item_t it;
        int    waitc;
        waitc     = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        while (!req_ready && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (!req_ready) begin
            n_total++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", waitc);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        it.we    = we;
        it.addr  = addr;
        it.wdata = wd;
        it.err   = (32'(addr) >= NUM_BYTES);
        it.acc   = cyc;
        if (!we) begin
            it.rd   = it.err ? 8'h00 : ref_mem[addr];
            last_rd = it.rd;
        end else begin
            it.rd = last_rd;
            if (!it.err && upd) ref_mem[addr] = wd;
        end
        exp_q.push_back(it);
        @(negedge clk);
    endtask

    task automatic drain();
        int waitc;
        waitc = 0;
        req_valid = 1'b0;
        while (exp_q.size() > 0 && waitc < 200) begin
            @(negedge clk);
            waitc++;
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d responses outstanding", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        n_pass    = 0;
        n_total   = 0;
        cyc       = 0;
        run       = 0;
        last_rd   = 8'h00;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = 8'h00;
        do_seed   = 1'b1;
        for (int i = 0; i < NUM_BYTES; i++) begin
            seed_val[i] = 8'($urandom);
            ref_mem[i]  = seed_val[i];
        end
        rst_n = 1'b0;
        #12;
        chk("rst_ready", req_ready, 1);
        chk("rst_outs", {resp_valid, write_pulse, read_pulse, resp_err}, 0);
        chk("rst_wl", WL, 0);
        chk("rst_din_rdata", {sram_din, resp_rdata}, 0);
        @(negedge clk);
        do_seed = 1'b0;
        rst_n   = 1'b1;
        @(negedge clk);

        issue(1'b1, 4'd3, 8'hA5, 1'b1);
        drain();
        issue(1'b0, 4'd3, 8'h00, 1'b1);
        drain();
        issue(1'b1, 4'd7, 8'h3C, 1'b1);
        issue(1'b1, 4'd8, 8'hC3, 1'b1);
        drain();
        issue(1'b0, 4'd7, 8'h00, 1'b1);
        issue(1'b0, 4'd8, 8'h00, 1'b1);
        drain();
        issue(1'b0, 4'd14, 8'h00, 1'b1);
        drain();
        issue(1'b1, 4'd13, 8'h77, 1'b1);
        drain();

        // Reset during the first PULSE cycle, before any write edge reaches the byte.
        issue(1'b1, 4'd2, 8'hFF, 1'b0);
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        last_rd = 8'h00;
        #1;
        chk("abort_wp", write_pulse, 0);
        chk("abort_wl", WL, 0);
        chk("abort_ready", req_ready, 1);
        chk("abort_resp", resp_valid, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        issue(1'b0, 4'd2, 8'h00, 1'b1);
        drain();

        for (int n = 0; n < 60; n++) begin
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom), 1'b1);
            if ($urandom_range(0, 2) != 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        drain();

        for (int i = 0; i < NUM_BYTES; i++) chk("final_mem", sram_mem[i], ref_mem[i]);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
